// File: rtl/pj_biu_arbiter.sv
// Bus interface arbiter: shares one memory port between the ICU and DCU with
// alternating priority on conflicts, burst beat counting and an ack-silence timeout.
module pj_biu_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icu_req,
    input  logic        icu_type,
    input  logic [1:0]  icu_size,
    input  logic [29:0] icu_addr,
    input  logic        dcu_req,
    input  logic [2:0]  dcu_type,
    input  logic [1:0]  dcu_size,
    input  logic [29:0] dcu_addr,
    input  logic [31:0] dcu_wdata,
    input  logic [1:0]  mem_ack,
    output logic [1:0]  icu_ack,
    output logic [1:0]  dcu_ack,
    output logic        mem_req,
    output logic [2:0]  mem_type,
    output logic [1:0]  mem_size,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_abort,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ICU_XFER,
        DCU_XFER,
        TOUT
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_lastDcu;
    logic        w_lastDcuNext;
    logic [2:0]  r_beatCnt;
    logic [2:0]  w_beatCntNext;
    logic [7:0]  r_idleCnt;
    logic [7:0]  w_idleCntNext;
    logic [7:0]  w_idleInc;
    logic        r_memReq;
    logic        w_memReqNext;
    logic [2:0]  r_memType;
    logic [2:0]  w_memTypeNext;
    logic [1:0]  r_memSize;
    logic [1:0]  w_memSizeNext;
    logic [29:0] r_memAddr;
    logic [29:0] w_memAddrNext;
    logic [31:0] r_memWdata;
    logic [31:0] w_memWdataNext;
    logic        w_grantIcu;
    logic        w_grantDcu;

    // Idle counter saturates so it can never wrap past the abort threshold.
    assign w_idleInc = (r_idleCnt >= LP_TIMEOUT) ? LP_TIMEOUT : r_idleCnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_lastDcu  <= 1'b0;
            r_beatCnt  <= 3'd0;
            r_idleCnt  <= 8'd0;
            r_memReq   <= 1'b0;
            r_memType  <= 3'd0;
            r_memSize  <= 2'd0;
            r_memAddr  <= 30'd0;
            r_memWdata <= 32'd0;
        end else begin
            r_state    <= w_stateNext;
            r_lastDcu  <= w_lastDcuNext;
            r_beatCnt  <= w_beatCntNext;
            r_idleCnt  <= w_idleCntNext;
            r_memReq   <= w_memReqNext;
            r_memType  <= w_memTypeNext;
            r_memSize  <= w_memSizeNext;
            r_memAddr  <= w_memAddrNext;
            r_memWdata <= w_memWdataNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_lastDcuNext  = r_lastDcu;
        w_beatCntNext  = r_beatCnt;
        w_idleCntNext  = r_idleCnt;
        w_memReqNext   = r_memReq;
        w_memTypeNext  = r_memType;
        w_memSizeNext  = r_memSize;
        w_memAddrNext  = r_memAddr;
        w_memWdataNext = r_memWdata;
        w_grantIcu     = 1'b0;
        w_grantDcu     = 1'b0;
        icu_ack        = 2'b00;
        dcu_ack        = 2'b00;

        case (r_state)
            IDLE: begin
                // On a conflict the requester that did not win last time goes first.
                if (icu_req && dcu_req) begin
                    w_grantIcu = r_lastDcu;
                    w_grantDcu = !r_lastDcu;
                end else begin
                    w_grantIcu = icu_req;
                    w_grantDcu = dcu_req;
                end

                if (w_grantIcu) begin
                    w_stateNext    = ICU_XFER;
                    w_lastDcuNext  = 1'b0;
                    w_memTypeNext  = {2'b00, icu_type};
                    w_memSizeNext  = icu_size;
                    w_memAddrNext  = icu_addr;
                    w_memWdataNext = 32'd0;
                    w_beatCntNext  = (icu_size == 2'b11) ? 3'd4 : 3'd1;
                    w_idleCntNext  = 8'd0;
                    w_memReqNext   = 1'b1;
                end else if (w_grantDcu) begin
                    w_stateNext    = DCU_XFER;
                    w_lastDcuNext  = 1'b1;
                    w_memTypeNext  = dcu_type;
                    w_memSizeNext  = dcu_size;
                    w_memAddrNext  = dcu_addr;
                    w_memWdataNext = dcu_wdata;
                    w_beatCntNext  = (dcu_size == 2'b11) ? 3'd4 : 3'd1;
                    w_idleCntNext  = 8'd0;
                    w_memReqNext   = 1'b1;
                end
            end

            ICU_XFER, DCU_XFER: begin
                if (r_state == ICU_XFER) begin
                    icu_ack = mem_ack;
                end else begin
                    dcu_ack = mem_ack;
                end

                if (mem_ack[1]) begin
                    w_stateNext   = IDLE;
                    w_memReqNext  = 1'b0;
                    w_idleCntNext = 8'd0;
                end else if (mem_ack[0]) begin
                    w_idleCntNext = 8'd0;
                    w_beatCntNext = (r_beatCnt == 3'd0) ? 3'd0 : r_beatCnt - 3'd1;
                    if (r_beatCnt <= 3'd1) begin
                        w_stateNext  = IDLE;
                        w_memReqNext = 1'b0;
                    end
                end else begin
                    w_idleCntNext = w_idleInc;
                    if (w_idleInc == LP_TIMEOUT) begin
                        w_stateNext  = TOUT;
                        w_memReqNext = 1'b0;
                    end
                end
            end

            TOUT: begin
                // The last-grant flag still names the owner of the aborted transfer.
                if (r_lastDcu) begin
                    dcu_ack = 2'b10;
                end else begin
                    icu_ack = 2'b10;
                end
                w_stateNext = IDLE;
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign mem_req   = r_memReq;
    assign mem_type  = r_memType;
    assign mem_size  = r_memSize;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_abort = (r_state == TOUT);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pj_biu_arbiter.sv
// Self-checking bench for pj_biu_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_pj_biu_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        icu_req;
    logic        icu_type;
    logic [1:0]  icu_size;
    logic [29:0] icu_addr;
    logic        dcu_req;
    logic [2:0]  dcu_type;
    logic [1:0]  dcu_size;
    logic [29:0] dcu_addr;
    logic [31:0] dcu_wdata;
    logic [1:0]  mem_ack;
    logic [1:0]  icu_ack;
    logic [1:0]  dcu_ack;
    logic        mem_req;
    logic [2:0]  mem_type;
    logic [1:0]  mem_size;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_abort;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: one in-flight transfer, described by owner, beats left and silence
    bit          mBusy;
    bit          mAbort;
    bit          mOwnerDcu;
    bit          mLastDcu;
    int          mBeats;
    int          mSilent;
    logic [2:0]  mType;
    logic [1:0]  mSize;
    logic [29:0] mAddr;
    logic [31:0] mWdata;

    pj_biu_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .icu_req   (icu_req),
        .icu_type  (icu_type),
        .icu_size  (icu_size),
        .icu_addr  (icu_addr),
        .dcu_req   (dcu_req),
        .dcu_type  (dcu_type),
        .dcu_size  (dcu_size),
        .dcu_addr  (dcu_addr),
        .dcu_wdata (dcu_wdata),
        .mem_ack   (mem_ack),
        .icu_ack   (icu_ack),
        .dcu_ack   (dcu_ack),
        .mem_req   (mem_req),
        .mem_type  (mem_type),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_abort (mem_abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        icu_req   = 1'b0;
        icu_type  = 1'b0;
        icu_size  = 2'b00;
        icu_addr  = 30'd0;
        dcu_req   = 1'b0;
        dcu_type  = 3'd0;
        dcu_size  = 2'b00;
        dcu_addr  = 30'd0;
        dcu_wdata = 32'd0;
        mem_ack   = 2'b00;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset    = 1'b1;
        icu_req  = 1'b1;
        dcu_req  = 1'b1;
        icu_size = 2'b11;
        dcu_addr = 30'h3FFF_FFFF;
        mem_ack  = 2'b01;
        #1;
        checks++;
        if ({mem_req, mem_abort, busy, icu_ack, dcu_ack} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 0000000", {mem_req, mem_abort, busy, icu_ack, dcu_ack});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({mem_type, mem_size, mem_addr, mem_wdata} !== 67'b0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 0", {mem_type, mem_size, mem_addr, mem_wdata});
        end
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_held got %b want 00", {mem_req, busy});
        end
        @(negedge clk);
        clearInputs();
        reset = 1'b0;
    endtask

    task automatic test_icu_burst();
        doReset();
        @(negedge clk);
        icu_req  = 1'b1;
        icu_type = 1'b1;
        icu_size = 2'b11;
        icu_addr = 30'h100;
        #1;
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL burst_pregrant got %b want 00", {mem_req, busy});
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            mem_ack = 2'b01;
            #1;
            checks++;
            if ({mem_req, busy, icu_ack, dcu_ack} !== 6'b11_01_00) begin
                errors++;
                $display("[TB] FAIL burst_beat%0d got %b want 110100", b, {mem_req, busy, icu_ack, dcu_ack});
            end
            checks++;
            if ({mem_type, mem_size, mem_addr, mem_wdata} !== {3'b001, 2'b11, 30'h100, 32'd0}) begin
                errors++;
                $display("[TB] FAIL burst_fields%0d got %h want %h", b, {mem_type, mem_size, mem_addr, mem_wdata},
                         {3'b001, 2'b11, 30'h100, 32'd0});
            end
            if (b == 1) begin
                icu_addr = 30'h2AA;
                icu_size = 2'b00;
            end
        end
        @(negedge clk);
        mem_ack = 2'b00;
        #1;
        checks++;
        if ({mem_req, busy, icu_ack, dcu_ack} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL burst_done got %b want 000000", {mem_req, busy, icu_ack, dcu_ack});
        end
        icu_req = 1'b0;
    endtask

    task automatic test_conflict();
        doReset();
        @(negedge clk);
        icu_req   = 1'b1;
        icu_type  = 1'b1;
        icu_size  = 2'b00;
        icu_addr  = 30'h0AA;
        dcu_req   = 1'b1;
        dcu_type  = 3'b101;
        dcu_size  = 2'b00;
        dcu_addr  = 30'h155;
        dcu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 2'b01;
        #1;
        checks++;
        if ({mem_req, mem_type, mem_addr, mem_wdata} !== {1'b1, 3'b101, 30'h155, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL conflict_dcu_first got %h want %h", {mem_req, mem_type, mem_addr, mem_wdata},
                     {1'b1, 3'b101, 30'h155, 32'hDEAD_BEEF});
        end
        checks++;
        if ({icu_ack, dcu_ack} !== 4'b00_01) begin
            errors++;
            $display("[TB] FAIL conflict_dcu_ack got %b want 0001", {icu_ack, dcu_ack});
        end
        @(negedge clk);
        mem_ack = 2'b00;
        dcu_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL conflict_turnaround got %b want 00", {mem_req, busy});
        end
        @(negedge clk);
        mem_ack = 2'b01;
        #1;
        checks++;
        if ({mem_req, mem_type, mem_addr, mem_wdata} !== {1'b1, 3'b001, 30'h0AA, 32'd0}) begin
            errors++;
            $display("[TB] FAIL conflict_icu_second got %h want %h", {mem_req, mem_type, mem_addr, mem_wdata},
                     {1'b1, 3'b001, 30'h0AA, 32'd0});
        end
        checks++;
        if ({icu_ack, dcu_ack} !== 4'b01_00) begin
            errors++;
            $display("[TB] FAIL conflict_icu_ack got %b want 0100", {icu_ack, dcu_ack});
        end
        @(negedge clk);
        mem_ack = 2'b00;
        icu_req = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conflict_end got %b want 0", busy);
        end
    endtask

    task automatic test_error();
        doReset();
        @(negedge clk);
        dcu_req   = 1'b1;
        dcu_type  = 3'b010;
        dcu_size  = 2'b11;
        dcu_addr  = 30'h200;
        dcu_wdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 2'b01;
        #1;
        checks++;
        if ({mem_req, dcu_ack} !== 3'b1_01) begin
            errors++;
            $display("[TB] FAIL error_beat1 got %b want 101", {mem_req, dcu_ack});
        end
        @(negedge clk);
        mem_ack = 2'b10;
        #1;
        checks++;
        if ({icu_ack, dcu_ack} !== 4'b00_10) begin
            errors++;
            $display("[TB] FAIL error_ack got %b want 0010", {icu_ack, dcu_ack});
        end
        @(negedge clk);
        mem_ack = 2'b01;
        dcu_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, icu_ack, dcu_ack} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL error_ended got %b want 000000", {mem_req, busy, icu_ack, dcu_ack});
        end
        @(negedge clk);
        mem_ack = 2'b00;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_no_restart got %b want 0", mem_req);
        end
    endtask

    task automatic test_timeout();
        doReset();
        @(negedge clk);
        dcu_req   = 1'b1;
        dcu_type  = 3'b011;
        dcu_size  = 2'b00;
        dcu_addr  = 30'h077;
        dcu_wdata = 32'hCAFE_0001;
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({mem_req, mem_abort, busy, dcu_ack} !== 5'b1_0_1_00) begin
                errors++;
                $display("[TB] FAIL timeout_silent%0d got %b want 10100", c, {mem_req, mem_abort, busy, dcu_ack});
            end
        end
        @(negedge clk);
        dcu_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_abort, busy, icu_ack, dcu_ack} !== 7'b0_1_1_00_10) begin
            errors++;
            $display("[TB] FAIL timeout_abort got %b want 0110010", {mem_req, mem_abort, busy, icu_ack, dcu_ack});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_abort, busy, icu_ack, dcu_ack} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL timeout_idle got %b want 0000000", {mem_req, mem_abort, busy, icu_ack, dcu_ack});
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        @(negedge clk);
        icu_req  = 1'b1;
        icu_type = 1'b0;
        icu_size = 2'b11;
        icu_addr = 30'h300;
        @(negedge clk);
        mem_ack = 2'b01;
        @(negedge clk);
        mem_ack = 2'b01;
        #1;
        checks++;
        if (icu_ack !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midreset_beat2 got %b want 01", icu_ack);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_abort, busy, icu_ack, dcu_ack, mem_type, mem_size, mem_addr, mem_wdata} !== 74'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async got %h want 0",
                     {mem_req, mem_abort, busy, icu_ack, dcu_ack, mem_type, mem_size, mem_addr, mem_wdata});
        end
        @(negedge clk);
        mem_ack = 2'b00;
        reset   = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_abort, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midreset_release got %b want 000", {mem_req, mem_abort, busy});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({mem_req, busy, mem_addr} !== {2'b11, 30'h300}) begin
            errors++;
            $display("[TB] FAIL midreset_regrant got %h want %h", {mem_req, busy, mem_addr}, {2'b11, 30'h300});
        end
        icu_req = 1'b0;
    endtask

    // Advances the reference model across one rising edge using the inputs now applied.
    task automatic modelAdvance();
        bit pickDcu;
        if (mAbort) begin
            mAbort = 1'b0;
        end else if (mBusy) begin
            if (mem_ack[1]) begin
                mBusy = 1'b0;
            end else if (mem_ack == 2'b01) begin
                mSilent = 0;
                mBeats  = mBeats - 1;
                if (mBeats == 0) mBusy = 1'b0;
            end else begin
                mSilent = mSilent + 1;
                if (mSilent >= TMO) begin
                    mBusy  = 1'b0;
                    mAbort = 1'b1;
                end
            end
        end else if (icu_req || dcu_req) begin
            pickDcu   = dcu_req && (!icu_req || !mLastDcu);
            mOwnerDcu = pickDcu;
            mLastDcu  = pickDcu;
            mBusy     = 1'b1;
            mSilent   = 0;
            if (pickDcu) begin
                mType  = dcu_type;
                mSize  = dcu_size;
                mAddr  = dcu_addr;
                mWdata = dcu_wdata;
            end else begin
                mType  = {2'b00, icu_type};
                mSize  = icu_size;
                mAddr  = icu_addr;
                mWdata = 32'd0;
            end
            mBeats = (mSize == 2'b11) ? 4 : 1;
        end
    endtask

    task automatic test_random();
        logic [1:0] expIcuAck;
        logic [1:0] expDcuAck;
        int         r;
        bit         quiet;
        doReset();
        mBusy     = 1'b0;
        mAbort    = 1'b0;
        mOwnerDcu = 1'b0;
        mLastDcu  = 1'b0;
        mBeats    = 0;
        mSilent   = 0;
        mType     = 3'd0;
        mSize     = 2'd0;
        mAddr     = 30'd0;
        mWdata    = 32'd0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            quiet     = (cyc % 64) >= 48;
            icu_req   = ($urandom_range(0, 3) != 0);
            dcu_req   = ($urandom_range(0, 3) != 0);
            icu_type  = 1'($urandom);
            icu_size  = 2'($urandom);
            icu_addr  = 30'($urandom);
            dcu_type  = 3'($urandom);
            dcu_size  = 2'($urandom);
            dcu_addr  = 30'($urandom);
            dcu_wdata = $urandom;
            r = $urandom_range(0, 19);
            if (quiet) mem_ack = (r < 17) ? 2'b00 : 2'b01;
            else if (r < 6) mem_ack = 2'b00;
            else if (r < 17) mem_ack = 2'b01;
            else mem_ack = (r == 17) ? 2'b10 : 2'b11;
            #1;
            expIcuAck = 2'b00;
            expDcuAck = 2'b00;
            if (mBusy) begin
                if (mOwnerDcu) expDcuAck = mem_ack;
                else expIcuAck = mem_ack;
            end else if (mAbort) begin
                if (mOwnerDcu) expDcuAck = 2'b10;
                else expIcuAck = 2'b10;
            end
            checks++;
            if ({icu_ack, dcu_ack} !== {expIcuAck, expDcuAck}) begin
                errors++;
                $display("[TB] FAIL rand_ack cyc %0d got %b want %b", cyc, {icu_ack, dcu_ack}, {expIcuAck, expDcuAck});
            end
            checks++;
            if ({mem_req, mem_abort, busy} !== {mBusy, mAbort, mBusy | mAbort}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl cyc %0d got %b want %b", cyc, {mem_req, mem_abort, busy},
                         {mBusy, mAbort, mBusy | mAbort});
            end
            checks++;
            if ({mem_type, mem_size, mem_addr, mem_wdata} !== {mType, mSize, mAddr, mWdata}) begin
                errors++;
                $display("[TB] FAIL rand_fields cyc %0d got %h want %h", cyc, {mem_type, mem_size, mem_addr, mem_wdata},
                         {mType, mSize, mAddr, mWdata});
            end
            modelAdvance();
        end
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_icu_burst();
        test_conflict();
        test_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
